// File: rtl/quant_gain_pkg.sv
// Shared types for the quantizer gain sequencer: control/status word layouts,
// FSM states and the post-reset gain value.
package quant_gain_pkg;

  localparam logic [15:0] DEFAULT_GAIN = 16'h0100;

  // Software control word as delivered by the gain register.
  typedef struct packed {
    logic        wr_tog;
    logic        cm_tog;
    logic [1:0]  rsvd;
    logic [11:0] chan;
    logic [15:0] gain;
  } ctrl_word_t;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_COPY_RD = 3'd2,
    ST_COPY_WR = 3'd3
  } state_e;

  // Status word, MSB first.
  typedef struct packed {
    logic [23:0] commit_cnt;
    state_e      state;
    logic        active_bank;
    logic        overflow;
    logic        write_pending;
    logic        commit_pending;
    logic        busy;
  } status_t;

endpackage

// File: rtl/gain_tdp_ram.sv
// True-dual-port gain RAM: port A read-only, port B read/write, both with a
// registered output. The array itself is never reset.
module gain_tdp_ram #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_q,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_q
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= mem[a_addr];
      b_q <= mem[b_addr];
    end
  end

endmodule

// File: rtl/quant_gain_sequencer.sv
// Per-channel quantizer gain controller: software writes land in a shadow bank,
// commits swap banks at spectrum sync, readout streams the active gain.
module quant_gain_sequencer
  import quant_gain_pkg::*;
#(
  parameter int unsigned       N_CHAN       = 2048,
  parameter int unsigned       CHAN_W       = 11,
  parameter int unsigned       GAIN_W       = 16,
  parameter logic [GAIN_W-1:0] DEFAULT_GAIN = GAIN_W'(quant_gain_pkg::DEFAULT_GAIN)
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl_word,
  input  logic              sync_in,
  input  logic              din_valid,
  output logic [GAIN_W-1:0] gain_out,
  output logic              gain_valid,
  output logic              sync_out,
  output logic [31:0]       status_word
);

  localparam int unsigned       ADDR_W    = CHAN_W + 1;
  localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(2 * N_CHAN - 1);
  localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'(N_CHAN - 1);

  ctrl_word_t        ctrl_q;
  logic [1:0]        tog_qq;
  logic [1:0]        seen;
  logic              wr_evt, cm_evt;
  state_e            state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic              active_bank, bank_n;
  logic [23:0]       commit_cnt, cnt_n;
  logic              write_pending, commit_pending, overflow;
  logic [CHAN_W-1:0] hold_chan;
  logic [GAIN_W-1:0] hold_gain;
  logic              apply_wr, do_swap;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr, a_addr;
  logic [GAIN_W-1:0] b_din, b_q, a_q;
  logic [CHAN_W-1:0] rd_chan, ch_sel;
  logic [1:0]        vld_d, sync_d, init_d;
  status_t           status;
  logic              unused_ctrl;

  assign unused_ctrl = ^{ctrl_q.rsvd, ctrl_q.chan, ctrl_q.gain};

  // Toggle-edge detection; the first sample after reset only seeds the history.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ctrl_q <= '0;
      tog_qq <= '0;
      seen   <= '0;
    end else begin
      ctrl_q <= ctrl_word_t'(ctrl_word);
      tog_qq <= {ctrl_q.wr_tog, ctrl_q.cm_tog};
      seen   <= {seen[0], 1'b1};
    end
  end

  assign wr_evt = seen[1] & (ctrl_q.wr_tog ^ tog_qq[1]);
  assign cm_evt = seen[1] & (ctrl_q.cm_tog ^ tog_qq[0]);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state       <= ST_INIT;
      idx         <= '0;
      active_bank <= 1'b0;
      commit_cnt  <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      active_bank <= bank_n;
      commit_cnt  <= cnt_n;
    end
  end

  // Port B owner and bank sequencing.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    bank_n   = active_bank;
    cnt_n    = commit_cnt;
    b_we     = 1'b0;
    b_addr   = idx;
    b_din    = hold_gain;
    apply_wr = 1'b0;
    do_swap  = 1'b0;
    unique case (state)
      ST_INIT: begin
        b_we  = 1'b1;
        b_din = DEFAULT_GAIN;
        if (idx == INIT_LAST) begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (write_pending) begin
          b_we     = 1'b1;
          b_addr   = {~active_bank, hold_chan};
          apply_wr = 1'b1;
        end else if (commit_pending && sync_in) begin
          do_swap = 1'b1;
          bank_n  = ~active_bank;
          cnt_n   = commit_cnt + 24'd1;
          idx_n   = '0;
          state_n = ST_COPY_RD;
        end
      end
      ST_COPY_RD: begin
        b_addr  = {active_bank, idx[CHAN_W-1:0]};
        state_n = ST_COPY_WR;
      end
      ST_COPY_WR: begin
        b_we   = 1'b1;
        b_addr = {~active_bank, idx[CHAN_W-1:0]};
        b_din  = b_q;
        if (idx == COPY_LAST) begin
          state_n = ST_IDLE;
        end else begin
          idx_n   = idx + ADDR_W'(1);
          state_n = ST_COPY_RD;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  // New events win over same-cycle clears so nothing is dropped.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      write_pending  <= 1'b0;
      commit_pending <= 1'b0;
      overflow       <= 1'b0;
      hold_chan      <= '0;
      hold_gain      <= '0;
    end else begin
      if (wr_evt) begin
        write_pending <= 1'b1;
        hold_chan     <= ctrl_q.chan[CHAN_W-1:0];
        hold_gain     <= ctrl_q.gain[GAIN_W-1:0];
        if (write_pending) overflow <= 1'b1;
      end else if (apply_wr) begin
        write_pending <= 1'b0;
      end
      if (cm_evt)       commit_pending <= 1'b1;
      else if (do_swap) commit_pending <= 1'b0;
    end
  end

  assign ch_sel = sync_in ? '0 : rd_chan;

  // Readout pipeline: address register, then the RAM output register.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      rd_chan <= '0;
      a_addr  <= '0;
      vld_d   <= '0;
      sync_d  <= '0;
      init_d  <= '0;
    end else begin
      if (din_valid)    rd_chan <= ch_sel + CHAN_W'(1);
      else if (sync_in) rd_chan <= '0;
      a_addr <= {active_bank, ch_sel};
      vld_d  <= {vld_d[0], din_valid};
      sync_d <= {sync_d[0], sync_in};
      init_d <= {init_d[0], state == ST_INIT};
    end
  end

  gain_tdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (GAIN_W)
  ) u_ram (
    .clk    (user_clk),
    .rst_n  (user_rst_n),
    .a_addr (a_addr),
    .a_q    (a_q),
    .b_we   (b_we),
    .b_addr (b_addr),
    .b_din  (b_din),
    .b_q    (b_q)
  );

  assign gain_out   = init_d[1] ? DEFAULT_GAIN : a_q;
  assign gain_valid = vld_d[1];
  assign sync_out   = sync_d[1];

  assign status = '{commit_cnt, state, active_bank, overflow, write_pending,
                    commit_pending, state != ST_IDLE};
  assign status_word = status;

endmodule

// File: tb/tb_quant_gain_sequencer.sv
// Bench for quant_gain_sequencer: a table-level model (live and software gain
// tables plus a busy-cycle count) checked against the DUT every cycle.
module tb_quant_gain_sequencer;

  localparam int          N   = 8;
  localparam logic [15:0] DEF = 16'h0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ctrl_word = 32'h0;
  logic        sync_in = 1'b0;
  logic        din_valid = 1'b0;
  logic [15:0] gain_out;
  logic        gain_valid, sync_out;
  logic [31:0] status_word;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: what readout sees, what software has written, and the busy window.
  logic [15:0] live [N];
  logic [15:0] sw   [N];
  logic [15:0] cap  [N];
  int          busy_left;
  bit          in_init, m_bank, m_cp, m_wp, m_ovf;
  logic [23:0] m_cnt;
  logic [31:0] m_q, m_qq;
  int          seed, rdc;
  int          hold_ch;
  logic [15:0] hold_g;
  bit          pv [2];
  bit          ps [2];
  logic [15:0] pg [2];
  int          pc [2];

  quant_gain_sequencer #(
    .N_CHAN       (N),
    .CHAN_W       (3),
    .GAIN_W       (16),
    .DEFAULT_GAIN (DEF)
  ) dut (
    .user_clk    (clk),
    .user_rst_n  (rst_n),
    .ctrl_word   (ctrl_word),
    .sync_in     (sync_in),
    .din_valid   (din_valid),
    .gain_out    (gain_out),
    .gain_valid  (gain_valid),
    .sync_out    (sync_out),
    .status_word (status_word)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [2:0] st;
    if (in_init)                st = 3'd0;
    else if (busy_left == 0)    st = 3'd1;
    else if (busy_left % 2 == 0) st = 3'd2;
    else                        st = 3'd3;
    return {m_cnt, st, m_bank, m_ovf, m_wp, m_cp, busy_left != 0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit wev, cev, wp0, idle;
    int ch;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin live[i] = DEF; sw[i] = DEF; end
      busy_left = 2 * N; in_init = 1; m_bank = 0; m_cp = 0; m_wp = 0; m_ovf = 0;
      m_cnt = '0; m_q = '0; m_qq = '0; seed = 0; rdc = 0; hold_ch = 0; hold_g = '0;
      for (int i = 0; i < 2; i++) begin pv[i] = 0; ps[i] = 0; pg[i] = '0; pc[i] = 0; end
    end else begin
      wev  = (seed >= 2) && (m_q[31] != m_qq[31]);
      cev  = (seed >= 2) && (m_q[30] != m_qq[30]);
      wp0  = m_wp;
      idle = (busy_left == 0);
      ch   = sync_in ? 0 : rdc;
      pv[1] = pv[0]; ps[1] = ps[0]; pg[1] = pg[0]; pc[1] = pc[0];
      pv[0] = din_valid; ps[0] = sync_in; pg[0] = live[ch]; pc[0] = ch;
      if (din_valid) rdc = (ch + 1) % N;
      else if (sync_in) rdc = 0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) in_init = 0;
      end
      if (idle && m_wp) begin
        sw[hold_ch] = hold_g;
        m_wp = 0;
      end else if (idle && m_cp && sync_in) begin
        for (int i = 0; i < N; i++) live[i] = sw[i];
        m_bank = ~m_bank; m_cnt = m_cnt + 24'd1; m_cp = 0; busy_left = 2 * N;
      end
      if (wev) begin
        if (wp0) m_ovf = 1;
        m_wp = 1; hold_ch = int'(m_q[18:16]); hold_g = m_q[15:0];
      end
      if (cev) m_cp = 1;
      m_qq = m_q; m_q = ctrl_word;
      if (seed < 2) seed++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gain_valid", 32'(gain_valid), 32'(pv[1]));
      chk("sync_out", 32'(sync_out), 32'(ps[1]));
      chk("status_word", status_word, exp_status());
      if (pv[1]) begin
        chk("gain_out", 32'(gain_out), 32'(pg[1]));
        cap[pc[1]] = gain_out;
      end
    end
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sw_write(input int ch, input logic [15:0] g);
    @(negedge clk);
    ctrl_word = {~ctrl_word[31], ctrl_word[30], 2'b00, 12'(ch), g};
  endtask

  task automatic sw_commit();
    @(negedge clk);
    ctrl_word[30] = ~ctrl_word[30];
  endtask

  task automatic spectrum();
    for (int i = 0; i < N; i++) cap[i] = 16'hdead;
    @(negedge clk); sync_in = 1'b1;
    @(negedge clk); sync_in = 1'b0; din_valid = 1'b1;
    repeat (N) @(negedge clk);
    din_valid = 1'b0;
    skip(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset status", status_word, 32'h1);
    chk("reset gain_out", 32'(gain_out), 32'h0);
    chk("reset gain_valid", 32'(gain_valid), 32'h0);
    chk("reset sync_out", 32'(sync_out), 32'h0);
    rst_n = 1'b1;

    // Readout during INIT and after it.
    spectrum();
    for (int i = 0; i < N; i++) chk("init gain", 32'(cap[i]), 32'(DEF));
    skip(10);
    chk("init done status", status_word, 32'h20);
    spectrum();
    for (int i = 0; i < N; i++) chk("idle gain", 32'(cap[i]), 32'(DEF));

    // First commit.
    sw_write(3, 16'h0200); skip(3); sw_commit(); skip(3); spectrum();
    for (int i = 0; i < N; i++) chk("swap1 gain", 32'(cap[i]), (i == 3) ? 32'h0200 : 32'(DEF));
    skip(20);
    chk("swap1 status", status_word, 32'h130);
    chk("model live3", 32'(live[3]), 32'h0200);

    // Copy-back keeps the earlier write.
    sw_write(5, 16'h0050); skip(3); sw_commit(); skip(3); spectrum();
    chk("swap2 ch3", 32'(cap[3]), 32'h0200);
    chk("swap2 ch5", 32'(cap[5]), 32'h0050);
    chk("swap2 ch0", 32'(cap[0]), 32'(DEF));
    skip(20);
    chk("swap2 status", status_word, 32'h220);

    // Back-to-back writes during COPY overflow the holding register.
    sw_write(1, 16'h0111); skip(3); sw_commit(); skip(3);
    @(negedge clk); sync_in = 1'b1;
    @(negedge clk); sync_in = 1'b0;
    sw_write(6, 16'h0aaa); sw_write(6, 16'h0bbb);
    skip(25);
    chk("overflow status", status_word, 32'h338);
    sw_commit(); skip(3); spectrum();
    chk("ovf ch6", 32'(cap[6]), 32'h0bbb);
    chk("ovf ch1", 32'(cap[1]), 32'h0111);
    chk("ovf ch5", 32'(cap[5]), 32'h0050);
    chk("model sw6", 32'(sw[6]), 32'h0bbb);
    skip(20);
    chk("swap4 status", status_word, 32'h428);

    // Commit waits for sync; sync mid-spectrum restarts the channel count.
    sw_write(2, 16'h0222); skip(3); sw_commit(); skip(100);
    chk("pending status", status_word, 32'h42A);
    for (int i = 0; i < N; i++) cap[i] = 16'hdead;
    @(negedge clk); din_valid = 1'b1;
    repeat (4) @(negedge clk);
    sync_in = 1'b1;
    @(negedge clk); sync_in = 1'b0;
    repeat (7) @(negedge clk);
    din_valid = 1'b0;
    skip(3);
    chk("midsync ch2", 32'(cap[2]), 32'h0222);
    chk("midsync ch3", 32'(cap[3]), 32'h0200);
    skip(20);
    chk("swap5 status", status_word, 32'h538);

    // Reset in the middle of a copy.
    sw_write(4, 16'h0444); skip(3); sw_commit(); skip(3);
    @(negedge clk); sync_in = 1'b1; din_valid = 1'b1;
    @(negedge clk); sync_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (status_word[7:5] == 3'd3) break;
      @(negedge clk);
    end
    chk("reach copy_wr", 32'(status_word[7:5]), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst gain_out", 32'(gain_out), 32'h0);
    chk("midrst gain_valid", 32'(gain_valid), 32'h0);
    chk("midrst status", status_word, 32'h1);
    din_valid = 1'b0;
    skip(3);
    rst_n = 1'b1;
    skip(20);
    chk("reinit status", status_word, 32'h20);
    spectrum();
    chk("reinit ch3", 32'(cap[3]), 32'(DEF));
    chk("reinit ch4", 32'(cap[4]), 32'(DEF));
    chk("reinit ch6", 32'(cap[6]), 32'(DEF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/quant_gain_sequencer.md
Name: quant_gain_sequencer

Overview:
- Per-channel quantizer gain controller for the quant1/quant2 paths.
- Decodes the 32-bit software control word delivered by the ppc2simulink gain register into single-entry gain writes.
- Writes go to a shadow bank of a double-buffered gain table. Software commits are applied atomically at the next spectrum sync. After each swap the new active bank is copied back into the new shadow bank.
- Streams the gain for the current channel, aligned to the FFT output valid/sync.

Parameters:
- N_CHAN, 2048, channels per spectrum (power of 2).
- CHAN_W, 11, log2(N_CHAN); at most 12.
- GAIN_W, 16, gain width; at most 16.
- DEFAULT_GAIN, 16'h0100, value loaded into every entry of both banks after reset.

Ports:
- user_clk  in  1  fabric clock, single clock domain.
- user_rst_n  in  1  asynchronous active-low reset.
- ctrl_word  in  32  software word: [31] write toggle, [30] commit toggle, [27:16] channel, [GAIN_W-1:0] gain.
- sync_in  in  1  one-cycle spectrum-start pulse; the next din_valid is channel 0.
- din_valid  in  1  one channel sample present.
- gain_out  out  GAIN_W  gain for the channel.
- gain_valid  out  1  din_valid delayed 2 cycles.
- sync_out  out  1  sync_in delayed 2 cycles.
- status_word  out  32  [0] busy, [1] commit_pending, [2] write_pending, [3] overflow (sticky), [4] active_bank, [7:5] state, [31:8] commit count mod 2^24.

Behaviour:
- Reset values:
  - gain_out = 0, gain_valid = 0, sync_out = 0.
  - active_bank = 0, all pending flags = 0, overflow = 0, commit count = 0.
  - Channel counter = 0.
  - State = INIT.
- ctrl_word sampling: registered twice (ctrl_q, ctrl_qq).
  - A write event is ctrl_q[31] != ctrl_qq[31].
  - A commit event is ctrl_q[30] != ctrl_qq[30].
  - The first sample after reset seeds ctrl_qq and produces no event.
- Memory: one true-dual-port RAM of 2*N_CHAN x GAIN_W. Address = {bank, chan}.
  - Port A is read-only, for readout.
  - Port B is shared by INIT, COPY and software writes.
- Readout:
  - Channel counter: sync_in forces it to 0, and a din_valid in the same cycle uses channel 0.
  - Each din_valid increments the counter modulo N_CHAN (N_CHAN-1 wraps to 0).
  - Port A address is registered, then the RAM output is registered: 2-cycle latency.
  - gain_out reads from the bank that was active on the cycle din_valid was sampled.
  - In INIT, gain_out = DEFAULT_GAIN.
- State machine:
  - INIT: port B writes DEFAULT_GAIN to address idx for idx = 0 .. 2*N_CHAN-1, one per cycle. Then go to IDLE. busy = 1.
  - IDLE:
    - If write_pending: write {~active_bank, chan} <= gain and clear write_pending.
    - Else if commit_pending && sync_in: toggle active_bank, clear commit_pending, increment commit count, go to COPY_RD with idx = 0.
  - COPY_RD: port B reads {active_bank, idx}. Go to COPY_WR. busy = 1.
  - COPY_WR: port B writes {~active_bank, idx} <= read data.
    - If idx == N_CHAN-1, go to IDLE.
    - Otherwise increment idx and go to COPY_RD.
    - busy = 1.
- Write events:
  - Any write event sets write_pending and latches chan/gain into a one-deep holding register.
  - A write event while write_pending is already set sets overflow (sticky). The newer write overwrites the holding register.
  - A write event during INIT is held until IDLE.
- Commit events:
  - Commit events set commit_pending; repeated events are idempotent.
  - The swap requires IDLE && !write_pending. A pending write therefore always lands before its commit.
  - A commit arriving during COPY is deferred to the first sync after COPY ends.
  - A sync with no commit_pending changes nothing.
- Reset mid-operation: asynchronous return to all reset values and restart INIT. RAM contents are rewritten by INIT.
- Simultaneous write and commit events in one cycle: both flags are set. The write is applied first, then the swap happens at a later sync.

Decomposition:
- Package quant_gain_pkg:
  - ctrl_word bit positions.
  - status_word bit positions.
  - State enum (INIT, IDLE, COPY_RD, COPY_WR).
  - DEFAULT_GAIN.
- Sub-module gain_tdp_ram: inferred true-dual-port RAM with registered output on both ports and no reset on the array.

Test Plan:
- Reset, then wait for 2*N_CHAN INIT cycles (N_CHAN = 8) -> busy falls; status state = IDLE; every gain_out = 16'h0100 with gain_valid 2 cycles after din_valid.
- Toggle write bit with chan 3 / gain 16'h0200, then toggle commit, then pulse sync -> the spectrum after the swap shows 16'h0200 at channel 3 only; active_bank = 1; commit count = 1.
- After that copy completes (16 cycles), write chan 5 = 16'h0050, commit, sync -> channels 3 and 5 read 16'h0200 and 16'h0050 (the copy preserved the earlier write).
- Two write toggles on consecutive cycles during COPY -> overflow = 1; only the second value is applied in IDLE.
- Commit with no sync for 100 cycles -> active_bank unchanged, commit_pending = 1; assert sync mid-spectrum -> counter restarts at 0 and the swap takes effect.
- Assert user_rst_n low during COPY_WR -> outputs go to 0 immediately; INIT reloads defaults; the old gains are gone.
